// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the two-requester SPI arbiter.
package spi_arb_pkg;

  localparam int unsigned N_REQ           = 2;
  localparam int unsigned DATA_W_DEFAULT  = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational 2-way round-robin pick: a lone requester always wins, on contention
// the requester that was not served last wins.
module spi_rr_pick
  import spi_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last,
  output logic [N_REQ-1:0] win
);

  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master between two requesters.
// Optional WAIT timeout abort is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [N_REQ-1:0]  gnt,
  output logic [DATA_W-1:0] rdata,
  output logic [N_REQ-1:0]  rvalid,
  output logic [N_REQ-1:0]  err,
  output logic              busy,
  output logic              m_start,
  output logic [DATA_W-1:0] m_txdata,
  output logic [N_REQ-1:0]  cs_n,
  input  logic              m_done,
  input  logic [DATA_W-1:0] m_rxdata
);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  cs_n_q, cs_n_d;
  logic [DATA_W-1:0] txdata_q, txdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              last_q, last_d;
  logic [N_REQ-1:0]  win;
  logic [DATA_W-1:0] wdata_sel;
  logic              timeout_hit;

  spi_rr_pick u_pick (
    .req  (req),
    .last (last_q),
    .win  (win)
  );

  assign wdata_sel = win[1] ? wdata1 : wdata0;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] err_q, err_d;

  // Counter restarts on every entry into WAIT since it is held at zero elsewhere.
  assign cnt_d       = (state_q == StWait) ? cnt_q + CNT_W'(1) : '0;
  assign timeout_hit = (state_q == StWait) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign err_d       = (timeout_hit && !m_done) ? gnt_q : '0;
  assign err         = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = '0;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cs_n_d   = cs_n_q;
    txdata_d = txdata_q;
    rdata_d  = rdata_q;
    last_d   = last_q;
    case (state_q)
      StIdle: begin
        if (|req) begin
          state_d  = StLoad;
          gnt_d    = win;
          cs_n_d   = ~win;
          txdata_d = wdata_sel;
        end
      end
      StLoad:  state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        // A completion arriving on the timeout cycle still wins over the abort.
        if (m_done) begin
          rdata_d = m_rxdata;
          state_d = StDone;
        end else if (timeout_hit) begin
          gnt_d   = '0;
          cs_n_d  = '1;
          last_d  = gnt_q[1];
          state_d = StIdle;
        end
      end
      StDone: begin
        gnt_d   = '0;
        cs_n_d  = '1;
        last_d  = gnt_q[1];
        state_d = StIdle;
      end
      default: begin
        gnt_d   = '0;
        cs_n_d  = '1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      cs_n_q   <= '1;
      txdata_q <= '0;
      rdata_q  <= '0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cs_n_q   <= cs_n_d;
      txdata_q <= txdata_d;
      rdata_q  <= rdata_d;
      last_q   <= last_d;
    end
  end

  assign gnt      = gnt_q;
  assign cs_n     = cs_n_q;
  assign m_txdata = txdata_q;
  assign rdata    = rdata_q;
  assign busy     = (state_q != StIdle);
  assign m_start  = (state_q == StStart);
  assign rvalid   = (state_q == StDone) ? gnt_q : '0;

endmodule
